data_ram_responder: RTL and testbench

// - Responder end of the core's data-RAM interface: accepts load/store requests, returns one

---
 rtl/data_ram_responder_pkg.sv | 19 +
 rtl/data_ram_responder_if.sv | 27 ++
 rtl/data_ram_responder_queue.sv | 54 +++++
 rtl/data_ram_responder.sv | 97 +++++++++
 tb/tb_data_ram_responder.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/data_ram_responder_pkg.sv
// Shared types and widths for the data-RAM responder and its request queue.
// A queued request carries everything needed to complete it plus its acceptance time stamp.
package data_ram_params;

    localparam int CPU_DATA_WIDTH       = 32;
    localparam int STAMP_WIDTH          = 16;
    localparam int STROBE_WIDTH         = CPU_DATA_WIDTH / 8;
    localparam int MAX_WORD_INDEX_WIDTH = CPU_DATA_WIDTH - 2;

    // word_index holds the full byte address minus its lane bits; the top slices what it needs
    typedef struct packed {
        logic                            write;
        logic [MAX_WORD_INDEX_WIDTH-1:0] word_index;
        logic [STROBE_WIDTH-1:0]         write_strobe;
        logic [CPU_DATA_WIDTH-1:0]       write_data;
        logic [STAMP_WIDTH-1:0]          stamp;
    } data_ram_request_t;

endpackage

// File: rtl/data_ram_responder_if.sv
// Request/response bundle between the core's memory-access stage (master)
// and the data-RAM responder (slave).
interface data_ram_if;
    import data_ram_params::*;

    logic                        request_valid;
    logic                        request_write;
    logic [CPU_DATA_WIDTH-1:0]   request_address;
    logic [STROBE_WIDTH-1:0]     request_write_strobe;
    logic [CPU_DATA_WIDTH-1:0]   request_write_data;
    logic                        request_accept;
    logic                        data_ram_data_ready;
    logic [CPU_DATA_WIDTH-1:0]   data_ram_read_data;

    modport master (
        output request_valid, request_write, request_address,
               request_write_strobe, request_write_data,
        input  request_accept, data_ram_data_ready, data_ram_read_data
    );

    modport slave (
        input  request_valid, request_write, request_address,
               request_write_strobe, request_write_data,
        output request_accept, data_ram_data_ready, data_ram_read_data
    );

endinterface

// File: rtl/data_ram_responder_queue.sv
// In-order FIFO of accepted data-RAM requests.
// Only pointers and occupancy are reset; entry storage is plain registers.
module request_queue
    import data_ram_params::*;
#(
    parameter int DEPTH = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              push,
    input  data_ram_request_t push_data,
    input  logic              pop,
    output logic              full,
    output logic              empty,
    output data_ram_request_t head
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [PTR_W:0]    r_count;
    data_ram_request_t r_entries [DEPTH];

    logic w_do_push;
    logic w_do_pop;

    assign full      = (r_count == (PTR_W+1)'(DEPTH));
    assign empty     = (r_count == '0);
    assign w_do_push = push && !full;
    assign w_do_pop  = pop && !empty;
    assign head      = r_entries[r_rd_ptr];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (w_do_push) r_entries[r_wr_ptr] <= push_data;
    end

endmodule

// File: rtl/data_ram_responder.sv
// Data-RAM responder: queues load/store requests and completes them strictly in order
// after a minimum latency, against an internal byte-lane-writable word array.
module data_ram_responder
    import data_ram_params::*;
#(
    parameter int    WORD_ADDRESS_BITS = 12,
    parameter int    QUEUE_DEPTH       = 4,
    parameter int    LATENCY           = 2,
    parameter string INIT_FILE         = ""
) (
    input logic       clock,
    input logic       reset,
    data_ram_if.slave bus
);

    localparam int WORDS = 2 ** WORD_ADDRESS_BITS;
    // The pulse is registered, so the head is released one cycle before its pulse shows.
    localparam logic [STAMP_WIDTH-1:0] RELEASE_AGE = STAMP_WIDTH'(LATENCY - 1);
    // INIT_FILE images are loaded into r_mem hierarchically by the simulation harness.
    localparam bit INIT_IMAGE_GIVEN = (INIT_FILE != "");

    logic [STAMP_WIDTH-1:0]       r_stamp;
    logic                         r_data_ready;
    logic [CPU_DATA_WIDTH-1:0]    r_read_data;
    logic [CPU_DATA_WIDTH-1:0]    r_mem [WORDS];

    data_ram_request_t            w_push_entry;
    data_ram_request_t            w_head;
    logic                         w_full;
    logic                         w_empty;
    logic                         w_push;
    logic                         w_complete;
    logic [STAMP_WIDTH-1:0]       w_age;
    logic [WORD_ADDRESS_BITS-1:0] w_head_index;
    logic                         w_unused;

    assign bus.request_accept      = reset && !w_full;
    assign bus.data_ram_data_ready = r_data_ready;
    assign bus.data_ram_read_data  = r_read_data;

    assign w_push = bus.request_valid && bus.request_accept;

    assign w_push_entry = '{
        write:        bus.request_write,
        word_index:   bus.request_address[CPU_DATA_WIDTH-1:2],
        write_strobe: bus.request_write_strobe,
        write_data:   bus.request_write_data,
        stamp:        r_stamp
    };

    request_queue #(
        .DEPTH (QUEUE_DEPTH)
    ) u_queue (
        .clock     (clock),
        .reset     (reset),
        .push      (w_push),
        .push_data (w_push_entry),
        .pop       (w_complete),
        .full      (w_full),
        .empty     (w_empty),
        .head      (w_head)
    );

    assign w_age        = r_stamp - w_head.stamp;
    assign w_complete   = !w_empty && (w_age >= RELEASE_AGE);
    assign w_head_index = w_head.word_index[WORD_ADDRESS_BITS-1:0];

    // Lane bits and aliased upper address bits are intentionally dropped.
    assign w_unused = ^{bus.request_address[1:0],
                        w_head.word_index[MAX_WORD_INDEX_WIDTH-1:WORD_ADDRESS_BITS],
                        INIT_IMAGE_GIVEN};

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_stamp      <= '0;
            r_data_ready <= 1'b0;
            r_read_data  <= '0;
        end else begin
            r_stamp      <= r_stamp + 1'b1;
            r_data_ready <= w_complete;
            if (w_complete && !w_head.write) begin
                r_read_data <= r_mem[w_head_index];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (w_complete && w_head.write) begin
            for (int lane = 0; lane < STROBE_WIDTH; lane++) begin
                if (w_head.write_strobe[lane]) begin
                    r_mem[w_head_index][8*lane +: 8] <= w_head.write_data[8*lane +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_data_ram_responder.sv
// Directed and reference-model checks of data_ram_responder: a LATENCY=2 instance for
// timing/ordering/random traffic and a LATENCY=6 instance to fill the queue and test reset.
module tb_data_ram_responder;

    localparam int FAST_LAT = 2;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    data_ram_if ifa ();
    data_ram_if ifs ();

    data_ram_responder #(.LATENCY(FAST_LAT)) u_dut  (.clock(clock), .reset(reset), .bus(ifa));
    data_ram_responder #(.LATENCY(6))        u_slow (.clock(clock), .reset(reset), .bus(ifs));

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    always @(posedge clock) cyc++;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic set_a(input logic v, input logic w, input logic [31:0] a,
                         input logic [3:0] s, input logic [31:0] d);
        ifa.request_valid        = v;
        ifa.request_write        = w;
        ifa.request_address      = a;
        ifa.request_write_strobe = s;
        ifa.request_write_data   = d;
    endtask

    task automatic set_s(input logic v, input logic w, input logic [31:0] a,
                         input logic [3:0] s, input logic [31:0] d);
        ifs.request_valid        = v;
        ifs.request_write        = w;
        ifs.request_address      = a;
        ifs.request_write_strobe = s;
        ifs.request_write_data   = d;
    endtask

    // scoreboard for the random section on the fast instance
    typedef struct {
        bit          wr;
        logic [31:0] exp;
        int          acc;
    } sb_t;
    sb_t         sb[$];
    bit          sb_en   = 1'b0;
    int          n_pulse = 0;
    int          n_acc   = 0;
    logic [31:0] last_rd = '0;

    always @(negedge clock) begin
        sb_t e;
        if (sb_en && ifa.data_ram_data_ready) begin
            n_pulse++;
            chk("rnd_nonempty", 32'(sb.size() != 0), 1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("rnd_gap", 32'((cyc - e.acc) >= FAST_LAT), 1);
                if (!e.wr) begin
                    chk("rnd_load", ifa.data_ram_read_data, e.exp);
                    last_rd = e.exp;
                end else begin
                    chk("rnd_store_rd", ifa.data_ram_read_data, last_rd);
                end
            end
        end
    end

    int          pulse_at [8];
    logic [31:0] pulse_rd [8];
    int          np;
    bit          r5_taken;
    logic        acc_log [3];
    int          exp_at [5] = '{6, 7, 8, 9, 12};
    logic [31:0] mdl [8];
    bit          seen;

    initial begin
        set_a(0, 0, 0, 0, 0);
        set_s(0, 0, 0, 0, 0);
        #2 reset = 1'b0;

        // reset state
        @(negedge clock);
        chk("rst_ready", ifa.data_ram_data_ready, 0);
        chk("rst_rd", ifa.data_ram_read_data, 0);
        chk("rst_accept", ifa.request_accept, 0);
        @(negedge clock);
        reset = 1'b1;
        #1 chk("rel_accept", ifa.request_accept, 1);

        // preload: word 4 and word 8
        @(negedge clock); set_a(1, 1, 32'h10, 4'hF, 32'h1234_5678);
        @(negedge clock); set_a(1, 1, 32'h20, 4'hF, 32'h1111_2222);
        @(negedge clock); set_a(0, 0, 0, 0, 0);
        repeat (5) @(negedge clock);
        chk("pre_rd_hold", ifa.data_ram_read_data, 0);

        // single load, pulse exactly two cycles after acceptance
        @(negedge clock); set_a(1, 0, 32'h10, 4'h0, 0);
        chk("ld_accept", ifa.request_accept, 1);
        @(negedge clock); set_a(0, 0, 0, 0, 0);
        chk("ld_t1_ready", ifa.data_ram_data_ready, 0);
        @(negedge clock);
        chk("ld_t2_ready", ifa.data_ram_data_ready, 1);
        chk("ld_t2_rd", ifa.data_ram_read_data, 32'h1234_5678);
        @(negedge clock);
        chk("ld_t3_ready", ifa.data_ram_data_ready, 0);
        chk("ld_t3_rd", ifa.data_ram_read_data, 32'h1234_5678);

        // store then load of the same word, back to back
        @(negedge clock); set_a(1, 1, 32'h20, 4'b0011, 32'hAAAA_BBBB);
        @(negedge clock); set_a(1, 0, 32'h20, 4'h0, 0);
        chk("raw_t1_ready", ifa.data_ram_data_ready, 0);
        @(negedge clock); set_a(0, 0, 0, 0, 0);
        chk("raw_st_ready", ifa.data_ram_data_ready, 1);
        chk("raw_st_rd", ifa.data_ram_read_data, 32'h1234_5678);
        @(negedge clock);
        chk("raw_ld_ready", ifa.data_ram_data_ready, 1);
        chk("raw_ld_rd", ifa.data_ram_read_data, 32'h1111_BBBB);
        @(negedge clock);
        chk("raw_after", ifa.data_ram_data_ready, 0);

        // zero-strobe store, then aliased load of the same word
        @(negedge clock); set_a(1, 0, 32'h10, 4'h0, 0);
        @(negedge clock); set_a(1, 1, 32'h20, 4'h0, 32'hFFFF_FFFF);
        @(negedge clock); set_a(1, 0, 32'hABCD_C022, 4'h0, 0);
        chk("z_ld_ready", ifa.data_ram_data_ready, 1);
        chk("z_ld_rd", ifa.data_ram_read_data, 32'h1234_5678);
        @(negedge clock); set_a(0, 0, 0, 0, 0);
        chk("z_st_ready", ifa.data_ram_data_ready, 1);
        chk("z_st_rd", ifa.data_ram_read_data, 32'h1234_5678);
        @(negedge clock);
        chk("z_alias_ready", ifa.data_ram_data_ready, 1);
        chk("z_alias_rd", ifa.data_ram_read_data, 32'h1111_BBBB);
        @(negedge clock);
        chk("z_after", ifa.data_ram_data_ready, 0);

        // fill the LATENCY=6 queue with five consecutive requests
        np = 0;
        r5_taken = 1'b0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clock);
            if (ifs.data_ram_data_ready && np < 8) begin
                pulse_at[np] = i;
                pulse_rd[np] = ifs.data_ram_read_data;
                np++;
            end
            case (i)
                0: set_s(1, 1, 32'h0, 4'hF, 32'hA0A0_A0A0);
                1: set_s(1, 1, 32'h4, 4'hF, 32'hB1B1_B1B1);
                2: set_s(1, 0, 32'h0, 4'h0, 0);
                3: set_s(1, 1, 32'h0, 4'hF, 32'hC2C2_C2C2);
                default: begin
                    if (r5_taken) set_s(0, 0, 0, 0, 0);
                    else          set_s(1, 0, 32'h0, 4'h0, 0);
                end
            endcase
            if (i >= 4 && i <= 6 && !r5_taken) acc_log[i-4] = ifs.request_accept;
            if (i >= 4 && !r5_taken && ifs.request_accept) r5_taken = 1'b1;
        end
        chk("fill_acc_t4", acc_log[0], 0);
        chk("fill_acc_t5", acc_log[1], 0);
        chk("fill_acc_t6", acc_log[2], 1);
        chk("fill_pulses", np, 5);
        for (int k = 0; k < 5; k++) chk($sformatf("fill_at%0d", k), pulse_at[k], exp_at[k]);
        chk("fill_ld3_rd", pulse_rd[2], 32'hA0A0_A0A0);
        chk("fill_ld5_rd", pulse_rd[4], 32'hC2C2_C2C2);

        // async reset with three outstanding requests
        @(negedge clock); set_s(1, 1, 32'h0, 4'hF, 32'hDEAD_BEEF);
        @(negedge clock); set_s(1, 1, 32'h4, 4'hF, 32'h5555_5555);
        @(negedge clock); set_s(1, 1, 32'h0, 4'hF, 32'h7777_7777);
        @(negedge clock); set_s(0, 0, 0, 0, 0);
        chk("ar_pre_accept", ifs.request_accept, 1);
        chk("ar_pre_rd", ifs.data_ram_read_data, 32'hC2C2_C2C2);
        #2 reset = 1'b0;
        #1;
        chk("ar_ready", ifs.data_ram_data_ready, 0);
        chk("ar_rd", ifs.data_ram_read_data, 0);
        chk("ar_accept", ifs.request_accept, 0);
        @(negedge clock); reset = 1'b1;
        np = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clock);
            if (ifs.data_ram_data_ready) np++;
        end
        chk("ar_no_stale", np, 0);
        @(negedge clock); set_s(1, 0, 32'h0, 4'h0, 0);
        @(negedge clock); set_s(0, 0, 0, 0, 0);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clock);
            if (ifs.data_ram_data_ready) begin
                seen = 1'b1;
                chk("ar_word_kept", ifs.data_ram_read_data, 32'hC2C2_C2C2);
            end
        end
        chk("ar_load_seen", 32'(seen), 1);

        // random traffic against an in-order reference model (words 0..7, aliased upper bits)
        last_rd = ifa.data_ram_read_data;
        sb_en = 1'b1;
        for (int i = 0; i < 308; i++) begin
            logic        v, w;
            logic [2:0]  idx;
            logic [3:0]  s;
            logic [31:0] d, a;
            sb_t         e;
            @(negedge clock);
            if (i < 8) begin
                v = 1'b1; w = 1'b1; idx = 3'(i); s = 4'hF;
            end else begin
                v = ($urandom_range(0, 3) != 0);
                w = 1'($urandom_range(0, 1));
                idx = 3'($urandom_range(0, 7));
                s = 4'($urandom_range(0, 15));
            end
            d = $urandom;
            a = ($urandom & 32'hFFFF_C000) | (32'(idx) << 2) | 32'($urandom_range(0, 3));
            set_a(v, w, a, s, d);
            if (v && ifa.request_accept) begin
                if (w) begin
                    for (int b = 0; b < 4; b++) if (s[b]) mdl[idx][8*b +: 8] = d[8*b +: 8];
                end
                e.wr  = w;
                e.exp = mdl[idx];
                e.acc = cyc;
                sb.push_back(e);
                n_acc++;
            end
        end
        @(negedge clock); set_a(0, 0, 0, 0, 0);
        repeat (10) @(negedge clock);
        chk("rnd_pulse_count", n_pulse, n_acc);
        chk("rnd_drained", sb.size(), 0);
        sb_en = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
